// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency, single-ported memory between instruction fetch and data access.
// Data has priority. Fetch is forced through after MAX_STREAK data grants that were made while it waited.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_wmask,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_wmask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

  localparam logic [2:0] CNT_LOAD   = 3'(MEM_LAT - 1);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  state_t     state_reg;
  owner_t     owner_reg;
  logic [2:0] cnt_reg;
  logic [3:0] streak_reg;

  logic resp_cycle;
  logic issue_ok;
  logic fetch_win;
  logic issue;

  // The response cycle doubles as an issue slot, giving one access per MEM_LAT cycles.
  assign resp_cycle = (state_reg == ST_WAIT) && (cnt_reg == 3'd0);
  // The rst_n term keeps the grant paths quiet while reset is held.
  assign issue_ok   = rst_n && ((state_reg == ST_IDLE) || resp_cycle);
  assign fetch_win  = if_req && (!d_req || (streak_reg == STREAK_MAX));

  assign if_gnt = issue_ok && fetch_win;
  assign d_gnt  = issue_ok && d_req && !fetch_win;
  assign issue  = if_gnt || d_gnt;

  assign mem_en    = issue;
  assign mem_we    = d_gnt && d_we;
  assign mem_addr  = d_gnt ? d_addr : (if_gnt ? if_addr : '0);
  assign mem_wdata = mem_we ? d_wdata : '0;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_wmask
      assign mem_wmask[gi] = mem_we && d_wmask[gi];
    end
  endgenerate

  assign if_rvalid = resp_cycle && (owner_reg == OWN_IF);
  assign d_rvalid  = resp_cycle && (owner_reg == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;

  assign stall_if  = if_req && !if_gnt;
  assign stall_mem = (d_req && !d_gnt) ||
                     ((state_reg == ST_WAIT) && (owner_reg == OWN_D) && !d_rvalid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      owner_reg  <= OWN_NONE;
      cnt_reg    <= 3'd0;
      streak_reg <= 4'd0;
    end else begin
      if (issue) begin
        state_reg <= ST_WAIT;
        owner_reg <= if_gnt ? OWN_IF : OWN_D;
        cnt_reg   <= CNT_LOAD;
      end else if (state_reg == ST_WAIT) begin
        if (cnt_reg == 3'd0) begin
          state_reg <= ST_IDLE;
          owner_reg <= OWN_NONE;
        end else begin
          cnt_reg <= cnt_reg - 3'd1;
        end
      end

      // Streak only counts data grants that actually made fetch wait.
      if (if_gnt || !if_req) begin
        streak_reg <= 4'd0;
      end else if (d_gnt && (streak_reg != STREAK_MAX)) begin
        streak_reg <= streak_reg + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table on a MEM_LAT=2 instance,
// plus hand-written sequences for reset mid-flight and a MEM_LAT=1 fetch stream.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_wmask;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, stall_if, stall_mem;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;

  logic        l1_if_req;
  logic [31:0] l1_if_addr, l1_mem_rdata;
  logic        l1_if_gnt, l1_if_rvalid, l1_d_gnt, l1_d_rvalid, l1_mem_en, l1_mem_we;
  logic        l1_stall_if, l1_stall_mem;
  logic [31:0] l1_if_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata;
  logic [3:0]  l1_mem_wmask;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .MAX_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_wmask(d_wmask), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_STREAK(4)) dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(l1_if_req), .if_addr(l1_if_addr), .if_gnt(l1_if_gnt), .if_rvalid(l1_if_rvalid),
    .if_rdata(l1_if_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_wmask(4'h0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_gnt(l1_d_gnt), .d_rvalid(l1_d_rvalid), .d_rdata(l1_d_rdata),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_wmask(l1_mem_wmask), .mem_addr(l1_mem_addr),
    .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata),
    .stall_if(l1_stall_if), .stall_mem(l1_stall_mem)
  );

  typedef struct {
    logic [2:0]  req;   // {if_req, d_req, d_we}
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] dd;
    logic [3:0]  dm;
    logic [5:0]  ex;    // {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_we, d_rdata checked}
    logic [31:0] ma;
    logic [3:0]  mwm;
    logic [1:0]  st;    // {stall_if, stall_mem}
  } vec_t;

  vec_t vecs[34];

  function automatic vec_t mk(input logic [2:0] req, input logic [31:0] ia, input logic [31:0] da,
                              input logic [31:0] dd, input logic [3:0] dm, input logic [5:0] ex,
                              input logic [31:0] ma, input logic [3:0] mwm, input logic [1:0] st);
    vec_t v;
    v.req = req; v.ia = ia; v.da = da; v.dd = dd; v.dm = dm;
    v.ex = ex; v.ma = ma; v.mwm = mwm; v.st = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, " if_gnt"}, if_gnt, 1'b0);
    chk1({tag, " d_gnt"}, d_gnt, 1'b0);
    chk1({tag, " if_rvalid"}, if_rvalid, 1'b0);
    chk1({tag, " d_rvalid"}, d_rvalid, 1'b0);
    chk1({tag, " mem_en"}, mem_en, 1'b0);
    chk1({tag, " mem_we"}, mem_we, 1'b0);
    chk({tag, " mem_wmask"}, {28'b0, mem_wmask}, 32'h0);
    chk({tag, " mem_addr"}, mem_addr, 32'h0);
    chk({tag, " mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, " if_rdata"}, if_rdata, 32'h0);
    chk({tag, " d_rdata"}, d_rdata, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd_val;

    // Single fetch, then data-vs-fetch collision.
    vecs[0]  = mk(3'b100, 32'h100, 32'h0,    32'h0, 4'h0, 6'b100000, 32'h100,  4'h0, 2'b00);
    vecs[1]  = mk(3'b000, 32'h0,   32'h0,    32'h0, 4'h0, 6'b000000, 32'h0,    4'h0, 2'b00);
    vecs[2]  = mk(3'b000, 32'h0,   32'h0,    32'h0, 4'h0, 6'b001000, 32'h0,    4'h0, 2'b00);
    vecs[3]  = mk(3'b000, 32'h0,   32'h0,    32'h0, 4'h0, 6'b000000, 32'h0,    4'h0, 2'b00);
    vecs[4]  = mk(3'b110, 32'h200, 32'h2000, 32'h0, 4'hF, 6'b010000, 32'h2000, 4'h0, 2'b10);
    vecs[5]  = mk(3'b100, 32'h200, 32'h0,    32'h0, 4'h0, 6'b000000, 32'h0,    4'h0, 2'b11);
    vecs[6]  = mk(3'b100, 32'h200, 32'h0,    32'h0, 4'h0, 6'b100101, 32'h200,  4'h0, 2'b00);
    vecs[7]  = mk(3'b000, 32'h0,   32'h0,    32'h0, 4'h0, 6'b000000, 32'h0,    4'h0, 2'b00);
    vecs[8]  = mk(3'b000, 32'h0,   32'h0,    32'h0, 4'h0, 6'b001000, 32'h0,    4'h0, 2'b00);
    // Partial store.
    vecs[9]  = mk(3'b011, 32'h0, 32'h3004, 32'hDEADBEEF, 4'b0011, 6'b010010, 32'h3004, 4'b0011, 2'b00);
    vecs[10] = mk(3'b000, 32'h0,   32'h0,    32'h0, 4'h0, 6'b000000, 32'h0,    4'h0, 2'b01);
    vecs[11] = mk(3'b000, 32'h0,   32'h0,    32'h0, 4'h0, 6'b000100, 32'h0,    4'h0, 2'b00);
    // Starvation: four data grants, forced fetch, then data again with streak cleared.
    vecs[12] = mk(3'b110, 32'h500, 32'h4000, 32'h0, 4'h0, 6'b010000, 32'h4000, 4'h0, 2'b10);
    vecs[13] = mk(3'b110, 32'h500, 32'h4004, 32'h0, 4'h0, 6'b000000, 32'h0,    4'h0, 2'b11);
    vecs[14] = mk(3'b110, 32'h500, 32'h4004, 32'h0, 4'h0, 6'b010101, 32'h4004, 4'h0, 2'b10);
    vecs[15] = mk(3'b110, 32'h500, 32'h4008, 32'h0, 4'h0, 6'b000000, 32'h0,    4'h0, 2'b11);
    vecs[16] = mk(3'b110, 32'h500, 32'h4008, 32'h0, 4'h0, 6'b010101, 32'h4008, 4'h0, 2'b10);
    vecs[17] = mk(3'b110, 32'h500, 32'h400C, 32'h0, 4'h0, 6'b000000, 32'h0,    4'h0, 2'b11);
    vecs[18] = mk(3'b110, 32'h500, 32'h400C, 32'h0, 4'h0, 6'b010101, 32'h400C, 4'h0, 2'b10);
    vecs[19] = mk(3'b110, 32'h500, 32'h4010, 32'h0, 4'h0, 6'b000000, 32'h0,    4'h0, 2'b11);
    vecs[20] = mk(3'b110, 32'h500, 32'h4010, 32'h0, 4'h0, 6'b100101, 32'h500,  4'h0, 2'b01);
    vecs[21] = mk(3'b110, 32'h504, 32'h4010, 32'h0, 4'h0, 6'b000000, 32'h0,    4'h0, 2'b11);
    vecs[22] = mk(3'b110, 32'h504, 32'h4010, 32'h0, 4'h0, 6'b011000, 32'h4010, 4'h0, 2'b10);
    vecs[23] = mk(3'b110, 32'h504, 32'h4014, 32'h0, 4'h0, 6'b000000, 32'h0,    4'h0, 2'b11);
    vecs[24] = mk(3'b110, 32'h504, 32'h4014, 32'h0, 4'h0, 6'b010101, 32'h4014, 4'h0, 2'b10);
    vecs[25] = mk(3'b100, 32'h504, 32'h0,    32'h0, 4'h0, 6'b000000, 32'h0,    4'h0, 2'b11);
    vecs[26] = mk(3'b100, 32'h504, 32'h0,    32'h0, 4'h0, 6'b100101, 32'h504,  4'h0, 2'b00);
    vecs[27] = mk(3'b000, 32'h0,   32'h0,    32'h0, 4'h0, 6'b000000, 32'h0,    4'h0, 2'b00);
    vecs[28] = mk(3'b000, 32'h0,   32'h0,    32'h0, 4'h0, 6'b001000, 32'h0,    4'h0, 2'b00);
    vecs[29] = mk(3'b000, 32'h0,   32'h0,    32'h0, 4'h0, 6'b000000, 32'h0,    4'h0, 2'b00);
    // Data request raised and dropped during WAIT is never issued.
    vecs[30] = mk(3'b100, 32'h600, 32'h0,    32'h0, 4'h0, 6'b100000, 32'h600,  4'h0, 2'b00);
    vecs[31] = mk(3'b010, 32'h0,   32'h7000, 32'h0, 4'h0, 6'b000000, 32'h0,    4'h0, 2'b01);
    vecs[32] = mk(3'b000, 32'h0,   32'h0,    32'h0, 4'h0, 6'b001000, 32'h0,    4'h0, 2'b00);
    vecs[33] = mk(3'b000, 32'h0,   32'h0,    32'h0, 4'h0, 6'b000000, 32'h0,    4'h0, 2'b00);

    // Reset with both requests high: no grants, stalls follow their equations.
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b1; d_wmask = 4'hF;
    d_addr = 32'h80; d_wdata = 32'h12345678; mem_rdata = 32'hFFFF0000;
    l1_if_req = 1'b0; l1_if_addr = 32'h0; l1_mem_rdata = 32'h0;
    #3;
    chk_all_zero("reset");
    chk1("reset stall_if", stall_if, 1'b1);
    chk1("reset stall_mem", stall_mem, 1'b1);
    $display("reset asserted with if_req=1 d_req=1");
    @(posedge clk); @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wmask = 4'h0;
    rst_n = 1'b1;

    // Vector table: inputs driven 1 time unit after the edge, outputs sampled on the falling edge.
    for (int i = 0; i < 34; i++) begin
      if_req    = vecs[i].req[2];
      d_req     = vecs[i].req[1];
      d_we      = vecs[i].req[0];
      if_addr   = vecs[i].ia;
      d_addr    = vecs[i].da;
      d_wdata   = vecs[i].dd;
      d_wmask   = vecs[i].dm;
      rd_val    = 32'hC0DE0000 | 32'(i);
      mem_rdata = rd_val;
      @(negedge clk);
      $display("vec %0d: if_gnt=%b d_gnt=%b if_rvalid=%b d_rvalid=%b mem_en=%b addr=%h stall=%b%b",
               i, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_addr, stall_if, stall_mem);
      chk1($sformatf("v%0d if_gnt", i), if_gnt, vecs[i].ex[5]);
      chk1($sformatf("v%0d d_gnt", i), d_gnt, vecs[i].ex[4]);
      chk1($sformatf("v%0d if_rvalid", i), if_rvalid, vecs[i].ex[3]);
      chk1($sformatf("v%0d d_rvalid", i), d_rvalid, vecs[i].ex[2]);
      chk1($sformatf("v%0d mem_en", i), mem_en, vecs[i].ex[5] | vecs[i].ex[4]);
      chk1($sformatf("v%0d mem_we", i), mem_we, vecs[i].ex[1]);
      chk($sformatf("v%0d mem_wmask", i), {28'b0, mem_wmask}, {28'b0, vecs[i].mwm});
      chk1($sformatf("v%0d stall_if", i), stall_if, vecs[i].st[1]);
      chk1($sformatf("v%0d stall_mem", i), stall_mem, vecs[i].st[0]);
      if (vecs[i].ex[5] | vecs[i].ex[4])
        chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].ma);
      if (vecs[i].ex[1])
        chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].dd);
      if (vecs[i].ex[3])
        chk($sformatf("v%0d if_rdata", i), if_rdata, rd_val);
      if (vecs[i].ex[0])
        chk($sformatf("v%0d d_rdata", i), d_rdata, rd_val);
      @(posedge clk); #1;
    end

    // Load granted, then reset asserted in the next cycle while the response is outstanding.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000; mem_rdata = 32'hAAAA5555;
    @(negedge clk);
    chk1("rst_mid grant", d_gnt, 1'b1);
    $display("rst_mid: load 0x8000 granted d_gnt=%b", d_gnt);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    chk1("rst_mid stall_mem", stall_mem, 1'b1);
    $display("rst_mid: reset asserted mid-transaction");
    @(posedge clk); @(posedge clk); #1;
    d_req = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1($sformatf("post_rst%0d d_rvalid", k), d_rvalid, 1'b0);
      chk1($sformatf("post_rst%0d mem_en", k), mem_en, 1'b0);
      $display("post_rst %0d: d_rvalid=%b mem_en=%b", k, d_rvalid, mem_en);
      @(posedge clk); #1;
    end
    d_req = 1'b1; d_addr = 32'h9000;
    @(negedge clk);
    chk1("post_rst new d_gnt", d_gnt, 1'b1);
    chk("post_rst new addr", mem_addr, 32'h9000);
    $display("post_rst: new load d_gnt=%b addr=%h", d_gnt, mem_addr);
    @(posedge clk); #1;
    d_req = 1'b0;
    @(posedge clk); #1;
    mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    chk1("post_rst d_rvalid", d_rvalid, 1'b1);
    chk("post_rst d_rdata", d_rdata, 32'h0BADF00D);
    $display("post_rst: load response d_rvalid=%b d_rdata=%h", d_rvalid, d_rdata);
    @(posedge clk); #1;

    // MEM_LAT=1: back-to-back fetch stream 0x0, 0x4, 0x8.
    for (int k = 0; k < 4; k++) begin
      l1_if_req    = (k < 3);
      l1_if_addr   = 32'(k * 4);
      l1_mem_rdata = 32'hF00D0000 | 32'(k);
      @(negedge clk);
      $display("lat1 %0d: if_gnt=%b if_rvalid=%b addr=%h rdata=%h stall_if=%b",
               k, l1_if_gnt, l1_if_rvalid, l1_mem_addr, l1_if_rdata, l1_stall_if);
      chk1($sformatf("lat1_%0d if_gnt", k), l1_if_gnt, k < 3);
      chk1($sformatf("lat1_%0d if_rvalid", k), l1_if_rvalid, k > 0);
      chk1($sformatf("lat1_%0d stall_if", k), l1_stall_if, 1'b0);
      if (k < 3) chk($sformatf("lat1_%0d mem_addr", k), l1_mem_addr, 32'(k * 4));
      if (k > 0) chk($sformatf("lat1_%0d if_rdata", k), l1_if_rdata, 32'hF00D0000 | 32'(k));
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
